// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one word read per PC value, holds the returned
// instruction for decode, and steers the PC hold/increment controls.
module instr_fetch #(
  parameter int          TIMEOUT     = 16,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc_val,
  input  logic        fetch_en,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        pc_hold,
  output logic        pc_inc,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   instr_reg, instr_next;
  logic [31:0]   instr_pc_reg, instr_pc_next;
  logic [1:0]    code_reg, code_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          drop_reg, drop_next;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      instr_reg    <= RESET_INSTR;
      instr_pc_reg <= '0;
      code_reg     <= 2'd0;
      cnt_reg      <= '0;
      drop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      code_reg     <= code_next;
      cnt_reg      <= cnt_next;
      drop_reg     <= drop_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    code_next     = code_reg;
    cnt_next      = cnt_reg;
    drop_next     = drop_reg;

    case (state_reg)
      S_IDLE: begin
        if (fetch_en) begin
          if (pc_val[1:0] != 2'b00) begin
            state_next = S_FAULT;
            code_next  = 2'd1;
          end else if (!flush) begin
            addr_next  = pc_val;
            cnt_next   = '0;
            drop_next  = 1'b0;
            state_next = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (mem_ack) begin
          if (drop_reg || flush) begin
            // A redirect arrived while this read was outstanding: swallow the data.
            drop_next  = 1'b0;
            state_next = S_IDLE;
          end else begin
            instr_next    = mem_rdata;
            instr_pc_next = addr_reg;
            state_next    = S_VALID;
          end
        end else begin
          if (flush) drop_next = 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_next = S_FAULT;
            code_next  = 2'd2;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end

      S_VALID: begin
        if (flush) begin
          instr_next = RESET_INSTR;
          state_next = S_IDLE;
        end else if (instr_ready) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        // Fault is sticky; only clr leaves this state.
      end
    endcase
  end

  assign mem_addr    = addr_reg;
  assign mem_read    = (state_reg == S_REQ);
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = (state_reg == S_VALID);
  assign fault       = (state_reg == S_FAULT);
  assign fault_code  = code_reg;
  assign pc_inc      = (state_reg == S_VALID) && instr_ready && !flush;
  assign pc_hold     = (state_reg == S_REQ) || ((state_reg == S_VALID) && !pc_inc) ||
                       (state_reg == S_FAULT);

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- Takes pc_val, issues a single-beat read to instruction memory with a req/ack handshake, and holds the returned word for decode under a valid/ready handshake.
- Drives the PC's hold and increment controls, so the PC advances exactly once per delivered instruction.
- Detects misaligned PCs and memory timeouts as sticky faults.

Parameters:
- TIMEOUT, 16, maximum cycles mem_read may stay high without mem_ack before a timeout fault (must be ≥ 2).
- RESET_INSTR, 32'h0000_0013, value of instr after reset and on flush (NOP encoding).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous, active-high reset.
- pc_val  input  32  current PC from the program counter.
- fetch_en  input  1  permits a new fetch from IDLE.
- flush  input  1  redirect (branch/jump taken); discards the current or in-flight instruction.
- mem_addr  output  32  instruction memory read address, word aligned.
- mem_read  output  1  read request; held high until mem_ack.
- mem_ack  input  1  memory response valid; mem_rdata is valid in the same cycle.
- mem_rdata  input  32  instruction word from memory.
- instr  output  32  fetched instruction to decode.
- instr_pc  output  32  address instr was fetched from.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts instr this cycle.
- pc_hold  output  1  freezes the PC (connects to its Disable).
- pc_inc  output  1  one-cycle advance pulse to the PC (connects to its inc).
- fault  output  1  sticky fault flag.
- fault_code  output  2  0 none, 1 misaligned PC, 2 memory timeout.

Behaviour:
- **Reset.** clr sampled only at the rising edge, highest priority, legal in any state including mid-request. Next cycle:
  - state = IDLE; mem_read = 0; mem_addr = 0; instr = RESET_INSTR; instr_pc = 0; instr_valid = 0; fault = 0; fault_code = 0; timeout counter = 0; drop flag = 0.
  - A mem_ack arriving after reset is ignored.
- **States:** IDLE, REQ, VALID, FAULT.
- **IDLE**
  - If fetch_en and pc_val[1:0] == 0 and !flush: latch mem_addr = pc_val, go to REQ. First mem_read cycle is the next cycle (1-cycle issue latency).
  - If fetch_en and pc_val[1:0] != 0: go to FAULT with fault_code = 1; no memory request is issued.
  - Otherwise stay in IDLE.
- **REQ**
  - mem_read = 1; mem_addr is stable. The timeout counter increments each cycle without mem_ack.
  - On mem_ack:
    - If the drop flag is set, or flush is high this cycle: discard the data, clear the drop flag, go to IDLE.
    - Otherwise: instr = mem_rdata, instr_pc = mem_addr, go to VALID. instr_valid rises the cycle after the ack.
  - flush without ack: set the drop flag and keep the request high. Requests are never withdrawn; the memory must complete them.
  - Counter reaching TIMEOUT−1 with no ack: go to FAULT with fault_code = 2, and mem_read drops the next cycle.
- **VALID**
  - instr_valid = 1; instr and instr_pc are held stable until accepted.
  - instr_ready and !flush: transfer occurs, go to IDLE.
  - flush (any instr_ready): instr_valid drops next cycle, instr = RESET_INSTR, go to IDLE, no transfer.
- **FAULT**
  - Sticky until clr. mem_read = 0, instr_valid = 0, pc_hold = 1.
  - fault = 1 and fault_code are held; flush and fetch_en are ignored.
- **PC control outputs (combinational from state and inputs):**
  - pc_inc = (state == VALID) & instr_ready & !flush.
  - pc_hold = (state == REQ) | (state == VALID & !pc_inc) | (state == FAULT).
  - In IDLE, pc_hold = 0 so the PC may load a redirect target.
- **Throughput:** at most one fetch in flight. Best case is 3 cycles per instruction: IDLE → REQ with ack in the first cycle → VALID accepted immediately.
- **Width rules:**
  - The timeout counter is wide enough to hold TIMEOUT−1 and never wraps; it is cleared on entering REQ.
  - Addresses pass through unmodified; there is no address arithmetic in this block.

Test Plan:
- **Reset value check:** clr high 2 cycles while fetch_en = 1 → instr = 0x00000013, instr_valid = 0, mem_read = 0, fault = 0, pc_hold = 0.
- **Basic fetch:** pc_val = 0x00000010, fetch_en = 1, memory acks 2 cycles after mem_read with 0x00500093, instr_ready = 1 → mem_addr = 0x10; instr = 0x00500093 and instr_pc = 0x10 with one pulse each of instr_valid and pc_inc; pc_hold high through REQ.
- **Backpressure then flush:** instr_ready = 0 for 4 cycles in VALID → instr stable, pc_hold = 1, pc_inc = 0. Then flush = 1 → instr_valid = 0 next cycle, instr = 0x00000013, no pc_inc.
- **Flush during REQ:** flush 1 cycle before mem_ack (data 0xDEADBEEF) → instr_valid never asserts, returns to IDLE after the ack, next fetch uses the new pc_val.
- **Misaligned PC:** pc_val = 0x00000006 with fetch_en → fault = 1, fault_code = 1, mem_read never asserts. A later clr clears the fault.
- **Timeout:** TIMEOUT = 16, no mem_ack → mem_read high exactly 16 cycles, then fault_code = 2. A late mem_ack is ignored; clr in mid-REQ returns to IDLE with mem_read = 0 next cycle.
